sim_run_ctrl: RTL
=================

Name: sim_run_ctrl

Overview:
- Synthesizable run controller that replaces hand-written reset/timeout sequencing in the top-level benches.
- Sits between the bench clock source and the ysyxNonSoCFull-class DUT.
- Stretches the DUT reset, monitors per-hart commit and halt (ebreak) streams, and enforces a cycle timeout and a no-commit hang watchdog.
- Reports a sticky pass/fail/timeout/hang verdict with a single stop request the bench turns into $finish/$stop.

Parameters:
- NUM_HARTS, 1, number of commit/halt channels monitored.
- RESET_CYCLES, 4, cycles dut_reset is held after controller reset releases; must be ≥1.
- MAX_CYCLES, 5000000, RUN-state cycle limit before TIMEOUT.
- HANG_CYCLES, 100000, consecutive RUN cycles with no commit before HANG; 0 disables.
- CNT_W, 40, width of cycle and instruction counters.
- TRACE_DEPTH, 16, PC trace entries; power of two; used only with the optional feature.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-low.
- commit_valid  in  NUM_HARTS  one bit per hart; the hart retired an instruction this cycle.
- commit_pc  in  NUM_HARTS*32  retired PC, hart h at bits [32h+31:32h].
- halt_valid  in  NUM_HARTS  the hart executed ebreak this cycle.
- halt_code  in  NUM_HARTS*32  the hart's a0 value at halt.
- dut_reset  out  1  active-high reset to the DUT.
- sim_stop  out  1  sticky stop request.
- status  out  3  0 IDLE, 1 RUNNING, 2 PASS, 3 FAIL, 4 TIMEOUT, 5 HANG.
- exit_hart  out  HART_W  index of the halting hart; HART_W = max(1, clog2(NUM_HARTS)).
- exit_code  out  32  halt_code of the halting hart.
- cycle_cnt  out  CNT_W  cycles spent in RUN.
- inst_cnt  out  CNT_W  total commits across all harts.
- last_pc  out  32  most recent committed PC.

Behaviour:
- All outputs are registered.
- **reset low:** state HOLD, hold_cnt=0, dut_reset=1, sim_stop=0, status=IDLE, and exit_hart, exit_code, cycle_cnt, inst_cnt, last_pc, idle_cnt all 0.
- **Reset mid-operation:** asserting reset in any state returns to this condition on the next edge.
- **HOLD:**
  - hold_cnt increments each cycle with reset high.
  - When hold_cnt==RESET_CYCLES-1, the next state is RUN; dut_reset falls and status becomes RUNNING on that same edge.
  - commit_* and halt_* are ignored.
- **RUN, each cycle:**
  - cycle_cnt += 1, saturating at all-ones.
  - inst_cnt += popcount(commit_valid), saturating.
  - last_pc takes the PC of the highest-index committing hart; it holds if there is no commit.
  - idle_cnt clears on any commit, otherwise increments.
- **Termination, evaluated in RUN.** Priority within the same cycle is halt > timeout > hang.
  - **Halt:** lowest-index hart with halt_valid wins. exit_hart and exit_code are captured. status=PASS if the code is 0, else FAIL.
  - **Timeout:** cycle_cnt==MAX_CYCLES-1 → TIMEOUT.
  - **Hang:** HANG_CYCLES≠0 and idle_cnt==HANG_CYCLES-1 with no commit this cycle → HANG.
- **DONE:**
  - The edge after the termination event, sim_stop=1 and dut_reset=1 (DUT quiesced).
  - Counters, last_pc and the verdict freeze; inputs are ignored.
  - Only reset leaves DONE.
- **Counting around termination:**
  - A commit in the terminating cycle is counted, and its PC is captured.
  - cycle_cnt includes the terminating cycle.
- Halt and commit from different harts in the same cycle: both are honoured.

Optional Feature:
- Macro SIM_RUN_CTRL_PC_TRACE_EN.
- **Defined:**
  - Adds trace_rd_idx (input, clog2(TRACE_DEPTH)) and trace_rd_data (output, 32, combinational read).
  - A ring buffer of the last TRACE_DEPTH committed PCs is written in RUN.
  - Multiple commits in one cycle are written in ascending hart order, limited to min(NUM_HARTS, TRACE_DEPTH) writes.
  - The write pointer wraps modulo TRACE_DEPTH.
  - Index 0 is the newest entry. Unwritten entries read 0.
  - The buffer freezes in DONE and clears on reset.
- **Undefined:** no trace ports and no storage; last_pc is the only PC visibility.

Decomposition:
- Package sim_run_ctrl_pkg holds:
  - state enum (HOLD, RUN, DONE);
  - status code constants (ST_IDLE..ST_HANG);
  - a function for saturating add.
- One sub-module, sim_run_ctrl_trace_buf, contains the ring buffer and pointer. It is instantiated only under the macro.

Test Plan:
1. **Reset stretch:** RESET_CYCLES=4, release reset → dut_reset stays 1 for exactly 4 cycles, then 0 with status=1; commits driven during HOLD leave inst_cnt=0.
2. **Pass:** NUM_HARTS=1; 10 commits PC 0x80000000..0x80000024; halt_valid with code 0 on the 10th commit → status=2, inst_cnt=10, last_pc=0x80000024, sim_stop=1 on the next edge.
3. **Fail with multi-hart priority:** NUM_HARTS=2; both halt in the same cycle with codes 7 and 0 → exit_hart=0, exit_code=7, status=3.
4. **Timeout vs halt:** MAX_CYCLES=20, halt arrives in RUN cycle 20 → status=2. Rerun with no halt → status=4, cycle_cnt=20.
5. **Hang:** HANG_CYCLES=8, commits stop after cycle 3 → status=5 after 8 idle cycles. Rerun with HANG_CYCLES=0 → reaches TIMEOUT instead.
6. **Trace (macro on):** TRACE_DEPTH=4, 6 commits PC 1..6 → idx 0..3 read 6, 5, 4, 3; reset mid-RUN → all read 0, status=0.

Source files
------------

// File: rtl/sim_run_ctrl_pkg.sv
// Shared types, status encodings and helpers for the simulation run controller.
package sim_run_ctrl_pkg;

    // Controller sequencing: DUT reset stretch, active run, frozen verdict
    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Encodings presented on the status output
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RUNNING = 3'd1;
    localparam logic [2:0] ST_PASS    = 3'd2;
    localparam logic [2:0] ST_FAIL    = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;
    localparam logic [2:0] ST_HANG    = 3'd5;

    // Carrier width for sat_add; counters must be narrower than this
    localparam int unsigned SAT_W = 64;

    // a + b clamped to the all-ones value of a w-bit counter (w < SAT_W)
    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b,
                                                 input int unsigned      w);
        logic [SAT_W-1:0] lim;
        logic [SAT_W-1:0] sum;
        lim = (SAT_W'(1) << w) - SAT_W'(1);
        sum = a + b;
        return (sum > lim) ? lim : sum;
    endfunction

endpackage

// File: rtl/sim_run_ctrl_if.sv
// Per-hart commit and halt streams observed by the run controller.
//   commit_valid/commit_pc : retirement strobe and PC, hart h at pc[32h+:32]
//   halt_valid/halt_code   : ebreak strobe and a0 value, hart h at code[32h+:32]
// master: the DUT side that produces the streams; slave: the controller.
interface sim_run_ctrl_if #(
    parameter int unsigned NUM_HARTS = 1
);
    logic [NUM_HARTS-1:0]    commit_valid;
    logic [NUM_HARTS*32-1:0] commit_pc;
    logic [NUM_HARTS-1:0]    halt_valid;
    logic [NUM_HARTS*32-1:0] halt_code;

    modport master (output commit_valid, commit_pc, halt_valid, halt_code);
    modport slave  (input  commit_valid, commit_pc, halt_valid, halt_code);
endinterface

// File: rtl/sim_run_ctrl_trace_buf.sv
// Ring buffer of the most recently committed PCs.
//   clock, reset    : clock and synchronous active-low reset (clears contents)
//   wr_en_i         : capture commits this cycle (controller in RUN)
//   commit_valid_i  : per-hart commit strobes
//   commit_pc_i     : per-hart PCs, hart h at [32h+:32]
//   rd_idx_i        : 0 selects the newest entry
//   rd_data_c       : combinational read of the selected entry
module sim_run_ctrl_trace_buf
    import sim_run_ctrl_pkg::*;
#(
    parameter int unsigned NUM_HARTS   = 1,
    parameter int unsigned TRACE_DEPTH = 16,
    localparam int unsigned PTR_W      = $clog2(TRACE_DEPTH),
    localparam int unsigned MAX_WR     = (NUM_HARTS < TRACE_DEPTH) ? NUM_HARTS : TRACE_DEPTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en_i,
    input  logic [NUM_HARTS-1:0]    commit_valid_i,
    input  logic [NUM_HARTS*32-1:0] commit_pc_i,
    input  logic [PTR_W-1:0]        rd_idx_i,
    output logic [31:0]             rd_data_c
);

    logic [31:0]      mem_q [TRACE_DEPTH];
    logic [31:0]      mem_d [TRACE_DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] rd_addr;

    // Same-cycle commits land in ascending hart order, so the highest hart is newest
    always_comb begin
        int unsigned n_wr;
        mem_d = mem_q;
        ptr_d = ptr_q;
        n_wr  = 0;
        if (wr_en_i) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (commit_valid_i[h] && (n_wr < MAX_WR)) begin
                    mem_d[ptr_d] = commit_pc_i[32*h +: 32];
                    ptr_d        = ptr_d + PTR_W'(1);
                    n_wr         = n_wr + 1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_q <= '{default: '0};
            ptr_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
        end
    end

    // ptr_q points at the next free slot; newest entry sits one behind it
    assign rd_addr   = ptr_q - PTR_W'(1) - rd_idx_i;
    assign rd_data_c = mem_q[rd_addr];

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller for the top-level benches: stretches the DUT reset, counts
// cycles and commits, and latches a sticky PASS/FAIL/TIMEOUT/HANG verdict.
//   clock, reset   : clock and synchronous active-low controller reset
//   run_bus        : per-hart commit/halt streams (slave modport)
//   dut_reset      : active-high reset to the DUT, reasserted once done
//   sim_stop       : sticky stop request
//   status         : IDLE/RUNNING/PASS/FAIL/TIMEOUT/HANG
//   exit_hart/code : halting hart index and its a0 value
//   cycle_cnt      : RUN cycles, inst_cnt : total commits (both saturating)
//   last_pc        : most recent committed PC
// Optional macro SIM_RUN_CTRL_PC_TRACE_EN adds trace_rd_idx/trace_rd_data
// and a PC ring buffer of TRACE_DEPTH entries.
module sim_run_ctrl
    import sim_run_ctrl_pkg::*;
#(
    parameter int unsigned NUM_HARTS    = 1,
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned MAX_CYCLES   = 5000000,
    parameter int unsigned HANG_CYCLES  = 100000,
    parameter int unsigned CNT_W        = 40,
    parameter int unsigned TRACE_DEPTH  = 16,
    localparam int unsigned HART_W      = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1,
    localparam int unsigned HOLD_W      = $clog2(RESET_CYCLES + 1),
    localparam int unsigned TRC_W       = $clog2(TRACE_DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    sim_run_ctrl_if.slave     run_bus,
`ifdef SIM_RUN_CTRL_PC_TRACE_EN
    input  logic [TRC_W-1:0]  trace_rd_idx,
    output logic [31:0]       trace_rd_data,
`endif
    output logic              dut_reset,
    output logic              sim_stop,
    output logic [2:0]        status,
    output logic [HART_W-1:0] exit_hart,
    output logic [31:0]       exit_code,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  inst_cnt,
    output logic [31:0]       last_pc
);

    if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
        $error("sim_run_ctrl: RESET_CYCLES must be at least 1");
    end
    if ((TRACE_DEPTH < 2) || ((TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0)) begin : g_bad_trace_depth
        $error("sim_run_ctrl: TRACE_DEPTH must be a power of two >= 2");
    end

    state_e              state_q,     state_d;
    logic [HOLD_W-1:0]   hold_cnt_q,  hold_cnt_d;
    logic                dut_reset_q, dut_reset_d;
    logic                sim_stop_q,  sim_stop_d;
    logic [2:0]          status_q,    status_d;
    logic [HART_W-1:0]   exit_hart_q, exit_hart_d;
    logic [31:0]         exit_code_q, exit_code_d;
    logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]    inst_cnt_q,  inst_cnt_d;
    logic [31:0]         last_pc_q,   last_pc_d;
    logic [CNT_W-1:0]    idle_cnt_q,  idle_cnt_d;

    logic [CNT_W-1:0]    commit_cnt;
    logic                any_commit;
    logic [31:0]         newest_pc;
    logic                halt_hit;
    logic [HART_W-1:0]   halt_idx;
    logic [31:0]         halt_val;

    // Commit popcount, highest-index committing PC, lowest-index halting hart
    always_comb begin
        commit_cnt = '0;
        any_commit = 1'b0;
        newest_pc  = last_pc_q;
        halt_hit   = 1'b0;
        halt_idx   = '0;
        halt_val   = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (run_bus.commit_valid[h]) begin
                commit_cnt = commit_cnt + CNT_W'(1);
                any_commit = 1'b1;
                newest_pc  = run_bus.commit_pc[32*h +: 32];
            end
            if (run_bus.halt_valid[h] && !halt_hit) begin
                halt_hit = 1'b1;
                halt_idx = HART_W'(h);
                halt_val = run_bus.halt_code[32*h +: 32];
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        logic       term;
        logic [2:0] verdict;
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        dut_reset_d = dut_reset_q;
        sim_stop_d  = sim_stop_q;
        status_d    = status_q;
        exit_hart_d = exit_hart_q;
        exit_code_d = exit_code_q;
        cycle_cnt_d = cycle_cnt_q;
        inst_cnt_d  = inst_cnt_q;
        last_pc_d   = last_pc_q;
        idle_cnt_d  = idle_cnt_q;
        term        = 1'b0;
        verdict     = status_q;

        case (state_q)
            S_HOLD: begin
                if (hold_cnt_q == HOLD_W'(RESET_CYCLES - 1)) begin
                    state_d     = S_RUN;
                    dut_reset_d = 1'b0;
                    status_d    = ST_RUNNING;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            S_RUN: begin
                // Counting always applies, including the terminating cycle
                cycle_cnt_d = CNT_W'(sat_add(SAT_W'(cycle_cnt_q), SAT_W'(1), CNT_W));
                inst_cnt_d  = CNT_W'(sat_add(SAT_W'(inst_cnt_q), SAT_W'(commit_cnt), CNT_W));
                if (any_commit) begin
                    last_pc_d  = newest_pc;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = CNT_W'(sat_add(SAT_W'(idle_cnt_q), SAT_W'(1), CNT_W));
                end

                if (halt_hit) begin
                    term        = 1'b1;
                    verdict     = (halt_val == 32'd0) ? ST_PASS : ST_FAIL;
                    exit_hart_d = halt_idx;
                    exit_code_d = halt_val;
                end else if (cycle_cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
                    term    = 1'b1;
                    verdict = ST_TIMEOUT;
                end else if ((HANG_CYCLES != 0) && !any_commit &&
                             (idle_cnt_q == CNT_W'(HANG_CYCLES - 1))) begin
                    term    = 1'b1;
                    verdict = ST_HANG;
                end

                if (term) begin
                    state_d     = S_DONE;
                    status_d    = verdict;
                    sim_stop_d  = 1'b1;
                    dut_reset_d = 1'b1;
                end
            end
            default: begin
                // DONE: everything frozen until reset
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_HOLD;
            hold_cnt_q  <= '0;
            dut_reset_q <= 1'b1;
            sim_stop_q  <= 1'b0;
            status_q    <= ST_IDLE;
            exit_hart_q <= '0;
            exit_code_q <= '0;
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
            last_pc_q   <= '0;
            idle_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            dut_reset_q <= dut_reset_d;
            sim_stop_q  <= sim_stop_d;
            status_q    <= status_d;
            exit_hart_q <= exit_hart_d;
            exit_code_q <= exit_code_d;
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
            last_pc_q   <= last_pc_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    assign dut_reset = dut_reset_q;
    assign sim_stop  = sim_stop_q;
    assign status    = status_q;
    assign exit_hart = exit_hart_q;
    assign exit_code = exit_code_q;
    assign cycle_cnt = cycle_cnt_q;
    assign inst_cnt  = inst_cnt_q;
    assign last_pc   = last_pc_q;

`ifdef SIM_RUN_CTRL_PC_TRACE_EN
    sim_run_ctrl_trace_buf #(
        .NUM_HARTS   (NUM_HARTS),
        .TRACE_DEPTH (TRACE_DEPTH)
    ) u_trace_buf (
        .clock          (clock),
        .reset          (reset),
        .wr_en_i        (state_q == S_RUN),
        .commit_valid_i (run_bus.commit_valid),
        .commit_pc_i    (run_bus.commit_pc),
        .rd_idx_i       (trace_rd_idx),
        .rd_data_c      (trace_rd_data)
    );
`endif

endmodule
